// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and exception squashing of the control bundle.
module pipe_stage_skid #(
    parameter int DATA_W = 167,
    parameter int CTRL_W = 11,
    parameter int EXC_W  = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_exc,
    input  logic [EXC_W-1:0]  in_exc_code,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_exc,
    output logic [EXC_W-1:0]  out_exc_code,
    output logic              out_is_nop,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic [CTRL_W-1:0] r_head_ctrl;
    logic [DATA_W-1:0] r_head_data;
    logic              r_head_exc;
    logic [EXC_W-1:0]  r_head_code;

    logic              w_head_valid;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_retire;
    logic [CTRL_W-1:0] w_cap_ctrl;
    logic [1:0]        w_occ;

    assign w_accept   = in_valid & w_in_ready;
    assign w_retire   = w_head_valid & out_ready;
    // A faulting instruction keeps its payload but must cause no downstream side effects.
    assign w_cap_ctrl = in_exc ? '0 : in_ctrl;

    assign in_ready     = w_in_ready;
    assign out_valid    = w_head_valid;
    assign out_is_nop   = ~w_head_valid;
    assign out_ctrl     = w_head_valid ? r_head_ctrl : '0;
    assign out_data     = r_head_data;
    assign out_exc      = r_head_exc;
    assign out_exc_code = r_head_code;
    assign occupancy    = w_occ;

    generate
        if (SKID != 0) begin : g_skid
            state_t            r_state;
            logic              r_in_ready;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            logic              r_skid_exc;
            logic [EXC_W-1:0]  r_skid_code;

            // in_ready comes straight from a flop so out_ready never reaches it combinationally.
            assign w_in_ready   = r_in_ready;
            assign w_head_valid = (r_state != ST_EMPTY);
            assign w_occ        = r_state;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_head_ctrl <= '0;
                    r_head_data <= '0;
                    r_head_exc  <= 1'b0;
                    r_head_code <= '0;
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                    r_skid_exc  <= 1'b0;
                    r_skid_code <= '0;
                end else if (flush) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                r_head_ctrl <= w_cap_ctrl;
                                r_head_data <= in_data;
                                r_head_exc  <= in_exc;
                                r_head_code <= in_exc_code;
                                r_state     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (w_accept && w_retire) begin
                                r_head_ctrl <= w_cap_ctrl;
                                r_head_data <= in_data;
                                r_head_exc  <= in_exc;
                                r_head_code <= in_exc_code;
                            end else if (w_accept) begin
                                r_skid_ctrl <= w_cap_ctrl;
                                r_skid_data <= in_data;
                                r_skid_exc  <= in_exc;
                                r_skid_code <= in_exc_code;
                                r_state     <= ST_TWO;
                                r_in_ready  <= 1'b0;
                            end else if (w_retire) begin
                                r_state <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (w_retire) begin
                                r_head_ctrl <= r_skid_ctrl;
                                r_head_data <= r_skid_data;
                                r_head_exc  <= r_skid_exc;
                                r_head_code <= r_skid_code;
                                r_state     <= ST_ONE;
                                r_in_ready  <= 1'b1;
                            end
                        end
                        default: begin
                            r_state    <= ST_EMPTY;
                            r_in_ready <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_reg
            logic r_valid;

            assign w_in_ready   = ~r_valid | out_ready;
            assign w_head_valid = r_valid;
            assign w_occ        = {1'b0, r_valid};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid     <= 1'b0;
                    r_head_ctrl <= '0;
                    r_head_data <= '0;
                    r_head_exc  <= 1'b0;
                    r_head_code <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_accept) begin
                    r_valid     <= 1'b1;
                    r_head_ctrl <= w_cap_ctrl;
                    r_head_data <= in_data;
                    r_head_exc  <= in_exc;
                    r_head_code <= in_exc_code;
                end else if (w_retire) begin
                    r_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one skid build and one single-register build
// driven from shared stimulus, checked with immediate assertions.
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [10:0]  in_ctrl;
    logic [166:0] in_data;
    logic         in_exc;
    logic [4:0]   in_exc_code;
    logic         flush;
    logic         out_ready;

    logic         s_in_ready, s_out_valid, s_out_exc, s_out_is_nop;
    logic [10:0]  s_out_ctrl;
    logic [166:0] s_out_data;
    logic [4:0]   s_out_exc_code;
    logic [1:0]   s_occupancy;

    logic         r0_in_ready, r0_out_valid, r0_out_exc, r0_out_is_nop;
    logic [10:0]  r0_out_ctrl;
    logic [166:0] r0_out_data;
    logic [4:0]   r0_out_exc_code;
    logic [1:0]   r0_occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(167), .CTRL_W(11), .EXC_W(5), .SKID(1)) dut_skid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc), .in_exc_code(in_exc_code),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
        .out_data(s_out_data), .out_exc(s_out_exc), .out_exc_code(s_out_exc_code),
        .out_is_nop(s_out_is_nop), .occupancy(s_occupancy)
    );

    pipe_stage_skid #(.DATA_W(167), .CTRL_W(11), .EXC_W(5), .SKID(0)) dut_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc), .in_exc_code(in_exc_code),
        .flush(flush), .out_valid(r0_out_valid), .out_ready(out_ready), .out_ctrl(r0_out_ctrl),
        .out_data(r0_out_data), .out_exc(r0_out_exc), .out_exc_code(r0_out_exc_code),
        .out_is_nop(r0_out_is_nop), .occupancy(r0_occupancy)
    );

    task automatic chk(input string tag, input logic [166:0] got, input logic [166:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; in_exc = 1'b0; in_exc_code = '0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); in_ctrl = 11'($urandom); flush = 1'($urandom);
            in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_exc = 1'($urandom); in_exc_code = 5'($urandom); out_ready = 1'($urandom);
            step();
        end
        chk("rst_out_valid", 167'(s_out_valid), 167'd0);
        chk("rst_out_ctrl", 167'(s_out_ctrl), 167'd0);
        chk("rst_occupancy", 167'(s_occupancy), 167'd0);
        chk("rst_out_is_nop", 167'(s_out_is_nop), 167'd1);
        chk("rst_out_data", s_out_data, 167'd0);
        chk("rst0_out_valid", 167'(r0_out_valid), 167'd0);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_exc = 1'b0;
        in_ctrl = '0; in_data = '0; in_exc_code = '0;
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 167'(s_in_ready), 167'd1);
        $display("reset phase done");

        // Streaming 1..8 with continuous ready
        in_valid = 1'b1; out_ready = 1'b1;
        chk("stream_latency_empty", 167'(s_out_valid), 167'd0);
        for (int i = 1; i <= 8; i++) begin
            in_data = 167'(i); in_ctrl = 11'(i * 3);
            step();
            chk("stream_data", s_out_data, 167'(i));
            chk("stream_ctrl", 167'(s_out_ctrl), 167'(i * 3));
            chk("stream_valid", 167'(s_out_valid), 167'd1);
            chk("stream_in_ready", 167'(s_in_ready), 167'd1);
            $display("stream beat %0d out_data=%0h", i, s_out_data);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_occ", 167'(s_occupancy), 167'd0);

        // Backpressure: A and B held, C waits upstream
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 11'h005;
        in_data = 167'hA; step();
        chk("bp_occ1", 167'(s_occupancy), 167'd1);
        chk("bp_in_ready1", 167'(s_in_ready), 167'd1);
        in_data = 167'hB; step();
        chk("bp_occ2", 167'(s_occupancy), 167'd2);
        chk("bp_in_ready0", 167'(s_in_ready), 167'd0);
        chk("bp_head_A", s_out_data, 167'hA);
        in_data = 167'hC; step();
        chk("bp_hold_occ2", 167'(s_occupancy), 167'd2);
        chk("bp_hold_A", s_out_data, 167'hA);
        chk("bp_hold_ctrl", 167'(s_out_ctrl), 167'h005);
        out_ready = 1'b1; step();
        chk("bp_out_B", s_out_data, 167'hB);
        chk("bp_occ_after_B", 167'(s_occupancy), 167'd1);
        step();
        chk("bp_out_C", s_out_data, 167'hC);
        in_valid = 1'b0; step();
        chk("bp_drained", 167'(s_out_valid), 167'd0);
        $display("backpressure phase done");

        // Flush collision at occupancy 2
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 11'h3FF;
        in_data = 167'h1; step();
        in_data = 167'h2; step();
        chk("fl_occ2", 167'(s_occupancy), 167'd2);
        flush = 1'b1; in_data = 167'hD; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ0", 167'(s_occupancy), 167'd0);
        chk("fl_valid0", 167'(s_out_valid), 167'd0);
        chk("fl_ctrl0", 167'(s_out_ctrl), 167'd0);
        chk("fl_nop1", 167'(s_out_is_nop), 167'd1);
        chk("fl_in_ready", 167'(s_in_ready), 167'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_D", 167'(s_out_valid), 167'd0);
        end

        // Flush with one held entry drops a simultaneous accept
        out_ready = 1'b0; in_valid = 1'b1; in_data = 167'h1; step();
        chk("fl1_occ1", 167'(s_occupancy), 167'd1);
        flush = 1'b1; in_data = 167'hE; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_occ0", 167'(s_occupancy), 167'd0);
        chk("fl1_valid0", 167'(s_out_valid), 167'd0);
        chk("fl1_reg_valid0", 167'(r0_out_valid), 167'd0);
        $display("flush phase done");

        // Exception squash, then an ordinary entry keeps its control
        in_valid = 1'b1; in_ctrl = 11'h7FF; in_exc = 1'b1; in_exc_code = 5'd12;
        in_data = 167'h55; step();
        chk("exc_ctrl0", 167'(s_out_ctrl), 167'd0);
        chk("exc_flag", 167'(s_out_exc), 167'd1);
        chk("exc_code", 167'(s_out_exc_code), 167'd12);
        chk("exc_data", s_out_data, 167'h55);
        chk("exc_reg_ctrl0", 167'(r0_out_ctrl), 167'd0);
        out_ready = 1'b1; in_exc = 1'b0; in_exc_code = 5'd0; in_data = 167'h66; step();
        chk("noexc_ctrl", 167'(s_out_ctrl), 167'h7FF);
        chk("noexc_flag", 167'(s_out_exc), 167'd0);
        chk("noexc_data", s_out_data, 167'h66);
        in_valid = 1'b0; step();
        $display("exception phase done");

        // Asynchronous reset mid-operation, asserted between edges
        out_ready = 1'b0; in_valid = 1'b1; in_data = 167'h77; step();
        chk("ar_valid_before", 167'(s_out_valid), 167'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid_cleared", 167'(s_out_valid), 167'd0);
        chk("ar_occ_cleared", 167'(s_occupancy), 167'd0);
        chk("ar_data_cleared", s_out_data, 167'd0);
        chk("ar_reg_valid_cleared", 167'(r0_out_valid), 167'd0);
        rst_n = 1'b1;
        step();
        $display("async reset phase done");

        // Single-register build: combinational in_ready
        out_ready = 1'b0; in_valid = 1'b1; in_data = 167'h31; step();
        chk("s0_valid", 167'(r0_out_valid), 167'd1);
        chk("s0_occ1", 167'(r0_occupancy), 167'd1);
        chk("s0_in_ready0", 167'(r0_in_ready), 167'd0);
        in_data = 167'h32; step();
        chk("s0_hold", r0_out_data, 167'h31);
        out_ready = 1'b1;
        #1;
        chk("s0_in_ready_comb", 167'(r0_in_ready), 167'd1);
        step();
        chk("s0_replace", r0_out_data, 167'h32);
        in_valid = 1'b0; step();
        chk("s0_drained", 167'(r0_out_valid), 167'd0);
        chk("s0_occ0", 167'(r0_occupancy), 167'd0);
        chk("s0_nop", 167'(r0_out_is_nop), 167'd1);
        $display("single-register phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
